// File: rtl/button_if.sv
// Button bundle between the raw switch inputs and the command consumer.
// cmd_valid is a pulse with no backpressure: the consumer takes cmd in the cycle cmd_valid is high.
interface button_if;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] cmd;
    logic       cmd_valid;

    modport master (
        output btn_raw,
        input  btn_level,
        input  cmd,
        input  cmd_valid
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output cmd,
        output cmd_valid
    );
endinterface

// File: rtl/button_ctrl.sv
// Five-button front end: synchronize, debounce, detect presses, arbitrate into one-hot command pulses.
// Optional up/down auto-repeat is compiled in when BTN_AUTOREPEAT_EN is defined.
module button_ctrl #(
    parameter int DB_CNT    = 100000,
    parameter int RPT_DELAY = 50000000,
    parameter int RPT_RATE  = 10000000
) (
    input  logic     clk,
    input  logic     rst_n,
    button_if.slave  bus
);
    localparam int NB = 5;
    localparam int CW = $clog2(DB_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

    if (DB_CNT < 2 || RPT_DELAY < 1 || RPT_RATE < 1) begin : g_param_check
        $error("button_ctrl: DB_CNT must be >= 2 and repeat timings >= 1");
    end

    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [CW-1:0] db_cnt [NB];
    logic [NB-1:0] level;
    logic [NB-1:0] level_d;
    logic [NB-1:0] press;
    logic [NB-1:0] rpt_evt;
    logic [NB-1:0] pending;
    logic [NB-1:0] pend_all;
    logic [NB-1:0] grant;
    logic [NB-1:0] cmd_q;
    logic          cmd_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.btn_raw;
            sync2 <= sync1;
        end
    end

    // A level change is accepted only after DB_CNT consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
            level   <= '0;
            level_d <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db_cnt[i] <= '0;
                    level[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                end
            end
            level_d <= level;
        end
    end

    assign press = level & ~level_d;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RPT_FIRST = RW'(RPT_DELAY);
    localparam logic [RW-1:0] RPT_NEXT  = RW'(RPT_RATE);

    logic [RW-1:0] rpt_cnt [1:2];
    logic [2:1]    rpt_armed;

    // First repeat waits RPT_DELAY after the level rose, later ones RPT_RATE apart.
    always_comb begin
        rpt_evt = '0;
        for (int i = 1; i <= 2; i++) begin
            if (level[i] && ((!rpt_armed[i] && rpt_cnt[i] == RPT_FIRST) ||
                             ( rpt_armed[i] && rpt_cnt[i] == RPT_NEXT))) begin
                rpt_evt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i <= 2; i++) begin
                rpt_cnt[i]   <= '0;
                rpt_armed[i] <= 1'b0;
            end
        end else begin
            for (int i = 1; i <= 2; i++) begin
                if (!level[i]) begin
                    rpt_cnt[i]   <= '0;
                    rpt_armed[i] <= 1'b0;
                end else if (rpt_evt[i]) begin
                    rpt_cnt[i]   <= RW'(1);
                    rpt_armed[i] <= 1'b1;
                end else begin
                    rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
                end
            end
        end
    end
`else
    assign rpt_evt = '0;
`endif

    // Lowest set bit wins: center (bit 0) has the highest priority.
    assign pend_all = pending | press | rpt_evt;
    assign grant    = pend_all & (~pend_all + NB'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending     <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
        end else begin
            pending     <= pend_all & ~grant;
            cmd_q       <= grant;
            cmd_valid_q <= |grant;
        end
    end

    assign bus.btn_level = level;
    assign bus.cmd       = cmd_q;
    assign bus.cmd_valid = cmd_valid_q;
endmodule
